// File: rtl/key_mode_ctrl.sv
// Two-button display-mode selector: sync + debounce + hold/auto-repeat per key,
// wrap-around mode counter, one-cycle change strobe and an activity LED timer.

// Per-key channel: synchronizer, debouncer and IDLE/HELD/REPEAT step generator.
module key_chan #(
  parameter int DEB  = 65000,
  parameter int LONG = 52000000,
  parameter int REP  = 13000000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic key_i,
  output logic step_o
);
  localparam int DW = $clog2(DEB + 1);
  localparam int TW = $clog2(((LONG > REP) ? LONG : REP) + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB - 1);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REP - 1);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  logic [1:0]    sync_q;
  logic          s_k;
  logic          db_q, db_d, db_prev_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          press;
  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;

  assign s_k   = sync_q[1];
  // Press is accepted the cycle after the debounced level falls.
  assign press = db_prev_q & ~db_q;

  // Synchronizer, debounce state and edge-history registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q    <= 2'b11;
      db_q      <= 1'b1;
      db_prev_q <= 1'b1;
      dcnt_q    <= '0;
    end else begin
      sync_q    <= {sync_q[0], key_i};
      db_q      <= db_d;
      db_prev_q <= db_q;
      dcnt_q    <= dcnt_d;
    end
  end

  // Debounce: any cycle matching the accepted level restarts the count.
  always_comb begin
    db_d   = db_q;
    dcnt_d = '0;
    if (s_k != db_q) begin
      if (dcnt_q == DEB_LAST) db_d = s_k;
      else                    dcnt_d = dcnt_q + DW'(1);
    end
  end

  // FSM state and hold/repeat timer registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next state: release from any state returns to IDLE and drops the count.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (press) state_d = HELD;
      end
      HELD: begin
        if (db_q) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (tmr_q == LONG_LAST) begin
          state_d = REPEAT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      REPEAT: begin
        if (db_q) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (tmr_q == REP_LAST) begin
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Step on press, on the first long-hold expiry and on each repeat expiry.
  always_comb begin
    step_o = 1'b0;
    case (state_q)
      IDLE:    step_o = press;
      HELD:    step_o = ~db_q & (tmr_q == LONG_LAST);
      REPEAT:  step_o = ~db_q & (tmr_q == REP_LAST);
      default: step_o = 1'b0;
    endcase
  end
endmodule

module key_mode_ctrl #(
  parameter int DEBOUNCE_CYC = 65000,
  parameter int LONG_CYC     = 52000000,
  parameter int REPEAT_CYC   = 13000000,
  parameter int NUM_MODES    = 14,
  parameter int LED_CYC      = 6500000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key1,
  input  logic       key2,
  output logic [3:0] dis_mode,
  output logic       mode_chg,
  output logic       led
);
  localparam int LW = $clog2(LED_CYC + 1);
  localparam logic [3:0]    MODE_LAST = 4'(NUM_MODES - 1);
  localparam logic [LW-1:0] LED_LOAD  = LW'(LED_CYC);

  logic [1:0]    keys, step;
  logic [3:0]    mode_q, mode_d;
  logic          chg_q, chg_d;
  logic [LW-1:0] led_q, led_d;

  assign keys = {key2, key1};

  for (genvar g = 0; g < 2; g++) begin : g_key
    key_chan #(.DEB(DEBOUNCE_CYC), .LONG(LONG_CYC), .REP(REPEAT_CYC)) u_chan (
      .clk_i  (clk),
      .rstn_i (rstn),
      .key_i  (keys[g]),
      .step_o (step[g])
    );
  end

  // Mode, change strobe and LED timer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q <= '0;
      chg_q  <= 1'b0;
      led_q  <= '0;
    end else begin
      mode_q <= mode_d;
      chg_q  <= chg_d;
      led_q  <= led_d;
    end
  end

  // Next mode with wrap; key1 wins a same-cycle collision, key2 is dropped.
  always_comb begin
    mode_d = mode_q;
    chg_d  = 1'b0;
    if (step[0]) begin
      mode_d = (mode_q == MODE_LAST) ? 4'd0 : mode_q + 4'd1;
      chg_d  = 1'b1;
    end else if (step[1]) begin
      mode_d = (mode_q == 4'd0) ? MODE_LAST : mode_q - 4'd1;
      chg_d  = 1'b1;
    end
  end

  // LED timer reloads with every change (retriggerable), else counts to 0.
  always_comb begin
    led_d = led_q;
    if (chg_d)               led_d = LED_LOAD;
    else if (led_q != '0)    led_d = led_q - LW'(1);
  end

  assign dis_mode = mode_q;
  assign mode_chg = chg_q;
  assign led      = (led_q != '0);
endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed bench for key_mode_ctrl with short timing parameters.
module tb_key_mode_ctrl;
  logic       clk = 1'b0;
  logic       rstn;
  logic       key1, key2;
  logic [3:0] dis_mode;
  logic       mode_chg, led;

  int n_checks = 0;
  int n_fail   = 0;

  key_mode_ctrl #(
    .DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(8), .NUM_MODES(14), .LED_CYC(10)
  ) dut (
    .clk(clk), .rstn(rstn), .key1(key1), .key2(key2),
    .dis_mode(dis_mode), .mode_chg(mode_chg), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k1;    // clocks key1 held low
    int k2;    // clocks key2 held low (same start)
    int mode;  // dis_mode after the window
    int chg;   // mode_chg pulses in the window
    int ledc;  // led-high cycles in the window
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int nchg, nled, n;
    bit found;
    int hits[$];

    tbl[0]  = '{3,  0,  0, 0, 0};   // glitch shorter than debounce
    tbl[1]  = '{10, 0,  1, 1, 10};  // clean press
    tbl[2]  = '{0,  10, 0, 1, 10};
    tbl[3]  = '{0,  10, 13, 1, 10}; // 0 -> 13 wrap
    tbl[4]  = '{10, 0,  0, 1, 10};  // 13 -> 0 wrap
    tbl[5]  = '{0,  3,  0, 0, 0};
    tbl[6]  = '{4,  0,  1, 1, 10};  // exactly the debounce length
    tbl[7]  = '{10, 0,  2, 1, 10};
    tbl[8]  = '{10, 0,  3, 1, 10};
    tbl[9]  = '{10, 0,  4, 1, 10};
    tbl[10] = '{10, 0,  5, 1, 10};
    tbl[11] = '{10, 10, 6, 1, 10};  // collision: key1 only
    tbl[12] = '{6,  10, 7, 1, 10};  // collision, key2 held longer
    tbl[13] = '{0,  8,  6, 1, 10};

    rstn = 1'b0; key1 = 1'b1; key2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dis_mode", int'(dis_mode), 0);
    chk("reset_mode_chg", int'(mode_chg), 0);
    chk("reset_led",      int'(led), 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_dis_mode", int'(dis_mode), 0);

    // Table-driven single presses
    for (int v = 0; v < 14; v++) begin
      nchg = 0; nled = 0;
      for (int c = 0; c < 60; c++) begin
        key1 = !(c < tbl[v].k1);
        key2 = !(c < tbl[v].k2);
        @(negedge clk);
        if (mode_chg) nchg++;
        if (led) nled++;
      end
      chk($sformatf("vec%0d_mode", v), int'(dis_mode), tbl[v].mode);
      chk($sformatf("vec%0d_chg", v),  nchg, tbl[v].chg);
      chk($sformatf("vec%0d_led", v),  nled, tbl[v].ledc);
    end

    // Long hold on key1 from mode 6: steps at +0,+20,+28,+36,+44,+52
    key1 = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (mode_chg) hits.push_back(c);
      if (hits.size() >= 6) key1 = 1'b1;
    end
    key1 = 1'b1;
    chk("hold_steps", hits.size(), 6);
    if (hits.size() >= 1) chk("hold_first", hits[0], 6);
    for (int i = 1; i < hits.size() && i < 6; i++)
      chk($sformatf("hold_gap%0d", i), hits[i] - hits[i-1], (i == 1) ? 20 : 8);
    chk("hold_mode", int'(dis_mode), 12);

    // key2 auto-repeat 12 -> 11 -> 10 -> 9, then reset mid-REPEAT
    found = 1'b0;
    key2 = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (dis_mode == 4'd9) found = 1'b1;
    end
    chk("reach_mode9", int'(found), 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_mode", int'(dis_mode), 0);
    chk("async_rst_led",  int'(led), 0);
    chk("async_rst_chg",  int'(mode_chg), 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    found = 1'b0;
    for (int c = 1; c <= 30 && !found; c++) begin
      @(negedge clk);
      if (mode_chg) begin
        found = 1'b1;
        n = c;
      end
    end
    chk("post_rst_latency", n, 7);
    chk("post_rst_mode", int'(dis_mode), 13);
    key2 = 1'b1;
    repeat (20) @(negedge clk);
    chk("final_mode", int'(dis_mode), 13);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
